// File: rtl/seq_alu_pkg.sv
// seq_alu shared definitions: op encodings and FSM states.
// Build option: SEQ_ALU_MUL_EN enables the sequential multiplier.
package seq_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int OPW = 3;

endpackage

// File: rtl/seq_alu_mul.sv
// Shift-add multiplier, WIDTH iterations per product.
// Only instantiated when SEQ_ALU_MUL_EN is defined.
module seq_alu_mul
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               running;

    // The start edge already performs the first iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else if (start) begin
            product <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand   <= {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier  <= b >> 1;
            cnt     <= CW'(WIDTH - 1);
            running <= 1'b1;
            done    <= 1'b0;
        end else if (running) begin
            if (mplier[0]) begin
                product <= product + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                running <= 1'b0;
                done    <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU with registered result and flags.
// Build option: SEQ_ALU_MUL_EN selects the multi-cycle MUL path.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             overflow,
    output logic             err
);

    localparam int MSB = WIDTH - 1;

    state_e state;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_e;
    logic             accept;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        sum     = {1'b0, A} + {1'b0, B};
        diff    = {1'b0, A} - {1'b0, B};
        shamt   = B[SHW-1:0];
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_e   = 1'b0;
        unique case (op)
            OP_ADD: begin
                alu_res = sum[MSB:0];
                alu_c   = sum[WIDTH];
                alu_v   = (A[MSB] == B[MSB])
                        && (sum[MSB] != A[MSB]);
            end
            OP_SUB: begin
                alu_res = diff[MSB:0];
                alu_c   = diff[WIDTH];
                alu_v   = (A[MSB] != B[MSB])
                        && (diff[MSB] != A[MSB]);
            end
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_XOR: alu_res = A ^ B;
            OP_SHL: alu_res = A << shamt;
            OP_SHR: alu_res = A >> shamt;
            OP_MUL: begin
`ifdef SEQ_ALU_MUL_EN
                alu_e = 1'b0;
`else
                alu_e = 1'b1;
`endif
            end
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    logic                 mul_start;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_prod;

    assign mul_start = accept && (op == OP_MUL);

    seq_alu_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (mul_prod)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            result   <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            err      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
`ifdef SEQ_ALU_MUL_EN
                        if (op == OP_MUL) begin
                            state <= S_BUSY;
                        end else begin
`endif
                            state    <= S_DONE;
                            result   <= alu_res;
                            carry    <= alu_c;
                            overflow <= alu_v;
                            err      <= alu_e;
                            zero     <= (alu_res == '0);
`ifdef SEQ_ALU_MUL_EN
                        end
`endif
                    end
                end
                S_BUSY: begin
`ifdef SEQ_ALU_MUL_EN
                    if (mul_done) begin
                        state    <= S_DONE;
                        result   <= mul_prod[MSB:0];
                        carry    <= 1'b0;
                        err      <= 1'b0;
                        overflow <= |mul_prod[2*WIDTH-1:WIDTH];
                        zero     <= (mul_prod[MSB:0] == '0);
                    end
`else
                    state <= S_IDLE;
`endif
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH 4 and 8.
// Define SEQ_ALU_MUL_EN to exercise the multiplier path.
module tb_seq_alu;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic       v4 = 0, r4, ov4, or4 = 0;
    logic [3:0] a4 = 0, b4 = 0, res4;
    logic [2:0] op4 = 0;
    logic       c4, z4, vf4, e4;

    logic       v8 = 0, r8, ov8, or8 = 0;
    logic [7:0] a8 = 0, b8 = 0, res8;
    logic [2:0] op8 = 0;
    logic       c8, z8, vf8, e8;

    int tests = 0;
    int fails = 0;
    int lat;
    int seen;

    seq_alu #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst),
        .in_valid(v4), .in_ready(r4),
        .A(a4), .B(b4), .op(op4),
        .out_valid(ov4), .out_ready(or4),
        .result(res4), .carry(c4), .zero(z4),
        .overflow(vf4), .err(e4)
    );

    seq_alu #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst),
        .in_valid(v8), .in_ready(r8),
        .A(a8), .B(b8), .op(op8),
        .out_valid(ov8), .out_ready(or8),
        .result(res8), .carry(c8), .zero(z8),
        .overflow(vf8), .err(e8)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic run4(input logic [3:0] a,
                        input logic [3:0] b,
                        input logic [2:0] o);
        @(negedge clk);
        a4 = a; b4 = b; op4 = o; v4 = 1'b1;
        @(posedge clk); #1;
        v4 = 1'b0;
        lat = 1;
        while (!ov4 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run8(input logic [7:0] a,
                        input logic [7:0] b,
                        input logic [2:0] o);
        @(negedge clk);
        a8 = a; b8 = b; op8 = o; v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic ack();
        @(negedge clk);
        or4 = 1'b1; or8 = 1'b1;
        @(posedge clk); #1;
        or4 = 1'b0; or8 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ov", 32'(ov8), 0);
        chk("rst_rdy", 32'(r8), 1);
        chk("rst_res", 32'(res8), 0);
        chk("rst_flg", 32'({c8, z8, vf8, e8}), 0);
        chk("rst_res4", 32'(res4), 0);
        @(negedge clk);
        rst = 1'b0;

        // WIDTH=4, A=0101 B=0011
        run4(4'b0101, 4'b0011, 3'b000);
        chk("w4_add_lat", lat, 1);
        chk("w4_add", 32'(res4), 32'b1000);
        chk("w4_add_cv", 32'({c4, vf4}), 32'b01);
        ack();
        run4(4'b0101, 4'b0011, 3'b001);
        chk("w4_sub_lat", lat, 1);
        chk("w4_sub", 32'(res4), 32'b0010);
        chk("w4_sub_c", 32'(c4), 0);
        ack();
        run4(4'b0101, 4'b0011, 3'b010);
        chk("w4_and", 32'(res4), 32'b0001);
        ack();
        run4(4'b0101, 4'b0011, 3'b011);
        chk("w4_or", 32'(res4), 32'b0111);
        ack();
        run4(4'b0101, 4'b0011, 3'b100);
        chk("w4_xor", 32'(res4), 32'b0110);
        chk("w4_xor_z", 32'(z4), 0);
        ack();
        run4(4'b0101, 4'b0011, 3'b101);
        chk("w4_shl", 32'(res4), 32'b1000);
        chk("w4_shl_c", 32'(c4), 0);
        ack();
        run4(4'b0101, 4'b0011, 3'b110);
        chk("w4_shr_lat", lat, 1);
        chk("w4_shr", 32'(res4), 0);
        chk("w4_shr_z", 32'(z4), 1);
        ack();
        chk("w4_idle", 32'(r4), 1);

        // WIDTH=8 add/sub boundaries
        run8(8'h7F, 8'h01, 3'b000);
        chk("ovf_res", 32'(res8), 32'h80);
        chk("ovf_cvz", 32'({c8, vf8, z8}), 32'b010);
        ack();
        run8(8'hFF, 8'h01, 3'b000);
        chk("cy_res", 32'(res8), 0);
        chk("cy_cvz", 32'({c8, vf8, z8}), 32'b101);
        ack();
        run8(8'h03, 8'h05, 3'b001);
        chk("bw_res", 32'(res8), 32'hFE);
        chk("bw_cvz", 32'({c8, vf8, z8}), 32'b100);
        chk("bw_err", 32'(e8), 0);
        ack();
        run8(8'h80, 8'h09, 3'b110);
        chk("shr_lowbits", 32'(res8), 32'h40);
        ack();
        run8(8'h81, 8'h0F, 3'b101);
        chk("shl_disc", 32'(res8), 32'h80);
        ack();

        // Hold in DONE with out_ready low
        run8(8'h12, 8'h34, 3'b000);
        chk("hold_lat", lat, 1);
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; op8 = 3'b011; v8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_ov", 32'(ov8), 1);
            chk("hold_rdy", 32'(r8), 0);
            chk("hold_res", 32'(res8), 32'h46);
            chk("hold_flg", 32'({c8, z8, vf8, e8}), 0);
        end
        @(negedge clk);
        v8 = 1'b0; or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        chk("rel_ov", 32'(ov8), 0);
        chk("rel_rdy", 32'(r8), 1);
        chk("rel_res", 32'(res8), 32'h46);

`ifdef SEQ_ALU_MUL_EN
        run8(8'd13, 8'd11, 3'b111);
        chk("mul_lat", lat, 9);
        chk("mul_res", 32'(res8), 32'h8F);
        chk("mul_vz", 32'({vf8, z8, e8}), 0);
        ack();
        run8(8'h20, 8'h10, 3'b111);
        chk("mul2_lat", lat, 9);
        chk("mul2_res", 32'(res8), 0);
        chk("mul2_vz", 32'({vf8, z8}), 32'b11);
        ack();
        run4(4'd3, 4'd5, 3'b111);
        chk("mul4_lat", lat, 5);
        chk("mul4_res", 32'(res4), 32'hF);
        ack();

        // Reset during the third BUSY cycle
        @(negedge clk);
        a8 = 8'd13; b8 = 8'd11; op8 = 3'b111; v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0;
        chk("busy_rdy", 32'(r8), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ov", 32'(ov8), 0);
        chk("abort_rdy", 32'(r8), 1);
        chk("abort_res", 32'(res8), 0);
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (ov8) seen++;
        end
        chk("abort_quiet", seen, 0);
`else
        run8(8'd5, 8'd3, 3'b111);
        chk("nomul_lat", lat, 1);
        chk("nomul_res", 32'(res8), 0);
        chk("nomul_ez", 32'({e8, z8, vf8, c8}), 32'b1100);
        ack();
        run4(4'd5, 4'd3, 3'b111);
        chk("nomul4_lat", lat, 1);
        chk("nomul4_ez", 32'({e4, z4}), 32'b11);
        ack();
        run8(8'd2, 8'd2, 3'b000);
        chk("err_clr", 32'(e8), 0);
        chk("err_clr_res", 32'(res8), 4);
        ack();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
